// File: rtl/rs232_time_loader_if.sv
// rs232_time_loader_if
//   Groups the serial input and the parsed-time outputs of rs232_time_loader.
//   master: the loader (consumes rx, drives the time/status outputs).
//   slave : the surroundings (drive rx, consume the time/status outputs).
//   Signals:
//     rx        raw serial line, idles high
//     time_bcd  last accepted MM:SS preset, digits M1 M0 S1 S0 from MSB
//     time_load one-cycle strobe when time_bcd is updated
//     frame_err one-cycle strobe when a stop bit samples low
//     busy      high while a character frame is in progress
interface rs232_time_loader_if;
  logic        rx;
  logic [15:0] time_bcd;
  logic        time_load;
  logic        frame_err;
  logic        busy;

  modport master (
    input  rx,
    output time_bcd, time_load, frame_err, busy
  );

  modport slave (
    output rx,
    input  time_bcd, time_load, frame_err, busy
  );
endinterface

// File: rtl/rs232_time_loader.sv
// rs232_time_loader
//   8N1 UART receiver plus a command parser that turns "MMSS<CR>" ASCII
//   presets into a 4-digit BCD value with a one-cycle load strobe for the
//   timer core.
//   Parameters:
//     CLK_FREQ  clk frequency in Hz
//     BAUD      line rate; DIV = CLK_FREQ/BAUD clocks per bit (>= 16)
//   Ports:
//     clk       single clock
//     rst_n     asynchronous active-low reset
//     io        rs232_time_loader_if.master (rx in; time_bcd, time_load,
//               frame_err, busy out)
module rs232_time_loader #(
  parameter int unsigned CLK_FREQ = 25175000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic                      clk,
  input  logic                      rst_n,
  rs232_time_loader_if.master       io
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
  // Counter reloads hold "cycles remaining minus one" so expiry is cnt == 0.
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  logic            rx_meta;
  logic            rxs;
  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            frame_err_r;
  logic            expire;
  logic            byte_valid;

  logic [15:0]     stage;
  logic [2:0]      count;
  logic            ovf;
  logic [15:0]     time_bcd_r;
  logic            time_load_r;
  logic            is_digit;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= io.rx;
      rxs     <= rx_meta;
    end
  end

  assign expire = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= HALF_M1;
          end
        end
        START: begin
          if (expire) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              cnt     <= FULL_M1;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (expire) begin
            shreg <= {rxs, shreg[7:1]};
            cnt   <= FULL_M1;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (expire) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              frame_err_r <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The parser consumes the byte on the stop-sample cycle itself so that
  // time_load lands exactly one cycle after that sample.
  assign byte_valid = (state == STOP) && expire && rxs;
  assign is_digit   = (shreg >= 8'h30) && (shreg <= 8'h39);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage       <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      time_bcd_r  <= '0;
      time_load_r <= 1'b0;
    end else begin
      time_load_r <= 1'b0;
      if (byte_valid) begin
        if (is_digit) begin
          if (count == 3'd4) begin
            ovf <= 1'b1;
          end else begin
            stage <= {stage[11:0], shreg[3:0]};
            count <= count + 3'd1;
          end
        end else begin
          // CR with exactly four digits and a valid tens-of-seconds digit
          // commits; any non-digit (accepted or not) restarts the command.
          if (shreg == 8'h0D && count == 3'd4 && !ovf && stage[7:4] <= 4'd5) begin
            time_bcd_r  <= stage;
            time_load_r <= 1'b1;
          end
          stage <= '0;
          count <= '0;
          ovf   <= 1'b0;
        end
      end
    end
  end

  assign io.time_bcd  = time_bcd_r;
  assign io.time_load = time_load_r;
  assign io.frame_err = frame_err_r;
  assign io.busy      = (state != IDLE);

endmodule

// File: tb/tb_rs232_time_loader.sv
// tb_rs232_time_loader
//   Directed bench for rs232_time_loader: a table of commands with expected
//   load counts and BCD values, followed by hand-written frame-error,
//   glitch and mid-frame reset sequences.
module tb_rs232_time_loader;

  localparam int unsigned CLK_FREQ = 320000;
  localparam int unsigned BAUD     = 10000;
  localparam int unsigned DIV      = CLK_FREQ / BAUD;   // 32

  logic clk;
  logic rst_n;
  rs232_time_loader_if io ();

  rs232_time_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks;
  int unsigned errors;
  int unsigned load_cnt;
  int unsigned ferr_cnt;

  typedef struct {
    logic [47:0] str;
    int unsigned len;
    int unsigned exp_loads;
    logic [15:0] exp_bcd;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitor; also checks that the two strobes never coincide.
  always @(negedge clk) begin
    if (io.time_load) load_cnt++;
    if (io.frame_err) ferr_cnt++;
    if (io.time_load || io.frame_err) begin
      checks++;
      if (io.time_load && io.frame_err) begin
        errors++;
        $display("FAIL strobe_exclusive: got load=1 ferr=1 expected not both");
      end
    end
  end

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    io.rx = 1'b0;
    wait_cycles(DIV);
    for (int unsigned i = 0; i < 8; i++) begin
      io.rx = b[i];
      wait_cycles(DIV);
    end
    io.rx = 1'b1;
    wait_cycles(DIV);
  endtask

  task automatic send_cmd(input logic [47:0] s, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      send_byte(s[8*(n-1-i) +: 8]);
  endtask

  function automatic vec_t mk(input logic [47:0] s, input int unsigned n,
                              input int unsigned loads, input logic [15:0] bcd);
    vec_t v;
    v.str = s; v.len = n; v.exp_loads = loads; v.exp_bcd = bcd;
    return v;
  endfunction

  int unsigned l0, f0;
  logic        busy_seen;

  initial begin
    checks = 0; errors = 0; load_cnt = 0; ferr_cnt = 0;
    vecs[0] = mk(48'({"1234",  8'h0D}), 5, 1, 16'h1234);
    vecs[1] = mk(48'({"0960",  8'h0D}), 5, 0, 16'h1234);
    vecs[2] = mk(48'({"0959",  8'h0D}), 5, 1, 16'h0959);
    vecs[3] = mk(48'({"12345", 8'h0D}), 6, 0, 16'h0959);
    vecs[4] = mk(48'({"123",   8'h0D}), 4, 0, 16'h0959);
    vecs[5] = mk(48'({"12a4",  8'h0D}), 5, 0, 16'h0959);
    vecs[6] = mk(48'({"4500",  8'h0D}), 5, 1, 16'h4500);
    vecs[7] = mk(48'({"5959",  8'h0D}), 5, 1, 16'h5959);

    io.rx = 1'b1;
    rst_n = 1'b0;
    wait_cycles(5);
    check("reset_bcd",  32'(io.time_bcd),  32'h0);
    check("reset_load", 32'(io.time_load), 32'h0);
    check("reset_ferr", 32'(io.frame_err), 32'h0);
    check("reset_busy", 32'(io.busy),      32'h0);
    rst_n = 1'b1;
    wait_cycles(2 * DIV);

    for (int unsigned v = 0; v < 8; v++) begin
      l0 = load_cnt; f0 = ferr_cnt;
      send_cmd(vecs[v].str, vecs[v].len);
      wait_cycles(2 * DIV);
      check($sformatf("vec%0d_loads", v), load_cnt - l0, vecs[v].exp_loads);
      check($sformatf("vec%0d_bcd", v),   32'(io.time_bcd), 32'(vecs[v].exp_bcd));
      check($sformatf("vec%0d_ferr", v),  ferr_cnt - f0, 0);
      check($sformatf("vec%0d_busy", v),  32'(io.busy), 32'h0);
    end

    // Stop bit held low for three bit times, then a valid command.
    l0 = load_cnt; f0 = ferr_cnt;
    io.rx = 1'b0;
    wait_cycles(DIV);
    for (int unsigned i = 0; i < 8; i++) begin
      io.rx = (i == 0 || i == 4 || i == 5);   // 0x31
      wait_cycles(DIV);
    end
    io.rx = 1'b0;
    wait_cycles(3 * DIV);
    check("ferr_busy_low", 32'(io.busy), 32'h1);
    io.rx = 1'b1;
    wait_cycles(2 * DIV);
    check("ferr_count", ferr_cnt - f0, 1);
    check("ferr_noload", load_cnt - l0, 0);
    check("ferr_busy_idle", 32'(io.busy), 32'h0);
    check("ferr_bcd_hold", 32'(io.time_bcd), 32'h5959);
    send_cmd(48'({"0101", 8'h0D}), 5);
    wait_cycles(2 * DIV);
    check("after_ferr_load", load_cnt - l0, 1);
    check("after_ferr_bcd", 32'(io.time_bcd), 32'h0101);
    check("after_ferr_ferr", ferr_cnt - f0, 1);

    // Short low glitch on an idle line.
    l0 = load_cnt; f0 = ferr_cnt;
    busy_seen = 1'b0;
    io.rx = 1'b0;
    wait_cycles(DIV / 4);
    io.rx = 1'b1;
    for (int unsigned i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      if (io.busy) busy_seen = 1'b1;
    end
    check("glitch_busy_seen", 32'(busy_seen), 32'h1);
    check("glitch_busy_end", 32'(io.busy), 32'h0);
    check("glitch_noload", load_cnt - l0, 0);
    check("glitch_noferr", ferr_cnt - f0, 0);
    check("glitch_bcd", 32'(io.time_bcd), 32'h0101);

    // Reset during the 5th data bit of the second digit.
    l0 = load_cnt; f0 = ferr_cnt;
    send_byte(8'h32);
    io.rx = 1'b0;
    wait_cycles(DIV);
    for (int unsigned i = 0; i < 4; i++) begin
      io.rx = (i == 1);                       // low nibble of 0x32
      wait_cycles(DIV);
    end
    io.rx = 1'b1;                            // bit 4 of 0x32
    wait_cycles(DIV / 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_bcd",  32'(io.time_bcd),  32'h0);
    check("midrst_load", 32'(io.time_load), 32'h0);
    check("midrst_ferr", 32'(io.frame_err), 32'h0);
    check("midrst_busy", 32'(io.busy),      32'h0);
    wait_cycles(4);
    rst_n = 1'b1;
    wait_cycles(2 * DIV);
    check("midrst_nopulse", (load_cnt - l0) + (ferr_cnt - f0), 0);
    send_cmd(48'({"2200", 8'h0D}), 5);
    wait_cycles(2 * DIV);
    check("postrst_load", load_cnt - l0, 1);
    check("postrst_bcd", 32'(io.time_bcd), 32'h2200);
    check("postrst_ferr", ferr_cnt - f0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs232_time_loader.md
# rs232_time_loader

- Receives ASCII time presets over the board RS232 line.
- Parses them into a 4-digit BCD MM:SS value and emits a one-cycle load strobe toward the timer core.
- Sits between top-level `RS232_RX` and the timer's programming path. It is the inbound counterpart of the display chain, which renders the timer's 16-bit BCD value outward.
- Contains an 8N1 UART receiver plus a small command parser FSM.

## Interface
Parameters:
- `CLK_FREQ`, 25175000: `clk` frequency in Hz.
- `BAUD`, 9600: line rate; `DIV = CLK_FREQ/BAUD` (integer division, ≥ 16).

Ports:
- `clk` in 1: single clock; everything is synchronous to it.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx` in 1: raw serial input; idles high; asynchronous to `clk`.
- `time_bcd` out 16: last accepted preset, digits M1 M0 S1 S0 in bits [15:12] [11:8] [7:4] [3:0].
- `time_load` out 1: one-cycle pulse when `time_bcd` is updated.
- `frame_err` out 1: one-cycle pulse when a stop bit samples low.
- `busy` out 1: high while a character frame is in progress.

## Operation
- Reset values: `time_bcd` = 16'h0000; `time_load` = 0; `frame_err` = 0; `busy` = 0. The synchronizer flops reset to 1, the FSMs to IDLE, and the digit count to 0.
- `rx` passes through a 2-flop synchronizer. All logic below uses the synchronized bit `rxs`.
- Receiver FSM:
  - IDLE → START: on `rxs` = 0; load baud counter with DIV/2.
  - START: when the counter expires, if `rxs` = 1 (glitch) → IDLE with no output; else → DATA with counter = DIV and bit index = 0.
  - DATA: sample `rxs` at each expiry into the shift register, LSB first. After 8 bits → STOP.
  - STOP: sample at expiry.
    - `rxs` = 1: deliver byte to parser, → IDLE.
    - `rxs` = 0: pulse `frame_err`, discard byte, → WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs` = 1, then → IDLE. A stuck-low line must not generate repeated frames.
  - `busy` = 1 in every state except IDLE.
- Parser, which receives each delivered byte once:
  - Byte '0'..'9' (0x30..0x39) with count < 4: shift the nibble in from the right into a 16-bit staging register, so the first digit ends in [15:12]. Increment count.
  - Digit with count = 4: set the overflow flag; the staging register is unchanged.
  - 0x0D (CR): accept only if count = 4, overflow clear, and staged S1 ≤ 5. On accept, copy staging to `time_bcd` and pulse `time_load`.
  - Every CR clears count, overflow and staging, whether or not it is accepted.
  - Any other byte clears count, overflow and staging; no load.
- `time_bcd` changes only on an accepted CR. It holds across rejected commands and frame errors.

## Timing
- Bit sample points are at DIV/2 after the detected falling edge, then every DIV cycles. Add 2 cycles of synchronizer delay.
- `time_load` asserts on the cycle after the CR stop-bit sample cycle. `time_bcd` takes its new value on that same cycle.
- `frame_err` asserts on the cycle after the failing stop-bit sample.
- A new start bit is recognised on the first cycle `rxs` = 0 in IDLE, so back-to-back frames with a single stop bit are supported.
- Asserting `rst_n` mid-frame aborts immediately. The partially received byte and staged digits are lost, and no pulse is generated.
- `time_load` and `frame_err` are never high together.

## Test plan
- Send "1234"+CR at 9600 baud → exactly one `time_load` pulse; `time_bcd` = 16'h1234. `frame_err` never pulses, `busy` low after the last stop bit.
- Send "0960"+CR → no `time_load` (S1 = 6 > 5); `time_bcd` keeps its previous value. Then "0959"+CR → `time_bcd` = 16'h0959 with one pulse.
- Send "12345"+CR, then "123"+CR, then "12a4"+CR → no load for any of them. A following "4500"+CR → `time_bcd` = 16'h4500.
- Send a frame with the stop bit forced low for 3 bit times, then "0101"+CR → one `frame_err` pulse, no spurious frame while the line is low, then `time_bcd` = 16'h0101.
- Apply a low glitch of DIV/4 cycles on idle `rx` → `busy` pulses briefly, then returns to IDLE with no byte delivered, no `frame_err` and no load.
- Assert `rst_n` low during the 5th data bit of the second digit, release, then send "2200"+CR → all outputs at reset values during reset; `time_bcd` = 16'h2200 afterwards.
